// File: rtl/sp_ram_pkg.sv
// Shared constants for the byte-enable single-port RAM: write-mode codes and
// the clear-engine state encoding.
package sp_ram_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/sp_ram_core.sv
// Storage array with one synchronous port: byte-enable write, registered read
// whose value on a write follows the configured write mode.
module sp_ram_core
    import sp_ram_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 8,
    parameter int MEMDEPTH = 256,
    parameter int WMODE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic                  rd_zero,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [DWIDTH-1:0]     din,
    output logic [DWIDTH-1:0]     dout
);

    localparam int NB = DWIDTH / 8;

    logic [DWIDTH-1:0] mem [MEMDEPTH];
    logic [DWIDTH-1:0] cur;
    logic [DWIDTH-1:0] merged;

    always_comb begin
        cur    = mem[addr];
        merged = cur;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
        end
    end

    // NOTE: the array has no reset so it can map onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we && be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
    end

    // NOTE: non-blocking updates mean cur still holds the pre-write word on a colliding edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (re) begin
            if (rd_zero)
                dout <= '0;
            else if (WMODE == WM_WRITE_FIRST && we)
                dout <= merged;
            else
                dout <= cur;
        end
    end

endmodule

// File: rtl/sp_ram_be.sv
// Single-port RAM with byte enables, 1/2-cycle read latency, write-collision
// modes, read-valid strobe and a one-word-per-cycle hardware clear engine.
module sp_ram_be
    import sp_ram_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 8,
    parameter int MEMDEPTH   = 256,
    parameter int RD_LAT     = 1,
    parameter int WMODE      = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wen,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [DWIDTH-1:0]     datai,
    input  logic                  clr,
    output logic [DWIDTH-1:0]     datao,
    output logic                  rvalid,
    output logic                  busy
);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $fatal(1, "sp_ram_be: RD_LAT must be 1 or 2");
    end
    if (WMODE < 0 || WMODE > 2) begin : g_bad_wmode
        $fatal(1, "sp_ram_be: WMODE must be 0, 1 or 2");
    end
    if (DWIDTH % 8 != 0 || DWIDTH <= 0) begin : g_bad_dw
        $fatal(1, "sp_ram_be: DWIDTH must be a positive multiple of 8");
    end
    if (MEMDEPTH < 1 || MEMDEPTH > (1 << AWIDTH)) begin : g_bad_depth
        $fatal(1, "sp_ram_be: MEMDEPTH must be in 1..2**AWIDTH");
    end

    localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(MEMDEPTH - 1);
    localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH + 1)'(MEMDEPTH);

    state_t             state, state_nxt;
    logic [AWIDTH-1:0]  ctr, ctr_nxt;
    logic               init_pend;

    // init_pend turns reset release into a one-shot clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ctr       <= '0;
            init_pend <= (CLR_ON_RST != 0);
        end else begin
            state     <= state_nxt;
            ctr       <= ctr_nxt;
            init_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        case (state)
            ST_IDLE: begin
                if (init_pend || clr) begin
                    state_nxt = ST_CLEAR;
                    ctr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                ctr_nxt = ctr + 1'b1;
                if (ctr == LAST) begin
                    state_nxt = ST_IDLE;
                    ctr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ctr_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == ST_CLEAR);

    logic                 access;
    logic                 in_range;
    logic                 core_we;
    logic                 core_re;
    logic [DWIDTH/8-1:0]  core_be;
    logic [AWIDTH-1:0]    core_addr;
    logic [DWIDTH-1:0]    core_din;
    logic [DWIDTH-1:0]    core_dout;
    logic                 v1;

    assign access    = en && !busy;
    assign in_range  = ({1'b0, addr} < DEPTH_W);
    // The clear engine owns the port while busy; user accesses are dropped.
    assign core_we   = busy || (access && wen && in_range);
    assign core_be   = busy ? '1 : be;
    assign core_addr = busy ? ctr : addr;
    assign core_din  = busy ? '0 : datai;
    assign core_re   = access && !(wen && (WMODE == WM_NO_CHANGE));

    sp_ram_core #(
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH),
        .MEMDEPTH (MEMDEPTH),
        .WMODE    (WMODE)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we      (core_we),
        .re      (core_re),
        .rd_zero (!in_range),
        .be      (core_be),
        .addr    (core_addr),
        .din     (core_din),
        .dout    (core_dout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) v1 <= 1'b0;
        else      v1 <= core_re;
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DWIDTH-1:0] d2;
        logic              v2;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                d2 <= '0;
                v2 <= 1'b0;
            end else begin
                if (v1) d2 <= core_dout;
                v2 <= v1;
            end
        end

        assign datao  = d2;
        assign rvalid = v2;
    end else begin : g_lat1
        assign datao  = core_dout;
        assign rvalid = v1;
    end

endmodule

// File: tb/tb_sp_ram_be.sv
// Directed bench for sp_ram_be: three configurations share one stimulus stream
// and are checked against a bench-side memory model through per-instance queues.
module tb_sp_ram_be;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, wen = 1'b0, clr = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] datai = 32'h0;

    logic [31:0] do_a, do_b, do_c;
    logic        rv_a, rv_b, rv_c;
    logic        bz_a, bz_b, bz_c;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int bcnt [3];

    logic [31:0] mdl [3][256];
    logic [31:0] last_out [3];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    logic [7:0] rd_list [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd9, 8'h7F, 8'd199, 8'd250, 8'd255};

    // u_a: READ_FIRST, lat 1, full depth; u_b: WRITE_FIRST, lat 2, depth 200; u_c: NO_CHANGE.
    sp_ram_be #(.DWIDTH(32), .AWIDTH(8), .MEMDEPTH(256), .RD_LAT(1), .WMODE(0), .CLR_ON_RST(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .be(be), .addr(addr), .datai(datai),
        .clr(clr), .datao(do_a), .rvalid(rv_a), .busy(bz_a));
    sp_ram_be #(.DWIDTH(32), .AWIDTH(8), .MEMDEPTH(200), .RD_LAT(2), .WMODE(1), .CLR_ON_RST(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .be(be), .addr(addr), .datai(datai),
        .clr(clr), .datao(do_b), .rvalid(rv_b), .busy(bz_b));
    sp_ram_be #(.DWIDTH(32), .AWIDTH(8), .MEMDEPTH(256), .RD_LAT(1), .WMODE(2), .CLR_ON_RST(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .be(be), .addr(addr), .datai(datai),
        .clr(clr), .datao(do_c), .rvalid(rv_c), .busy(bz_c));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dep(input int i);
        return (i == 1) ? 200 : 256;
    endfunction

    function automatic int lat(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int wm(input int i);
        return i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sb_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t sb_front(input int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic sb_push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    // Model one access for instance i and queue its expected read result.
    task automatic model_acc(input int i, input logic w, input logic [3:0] b,
                             input logic [7:0] a, input logic [31:0] d);
        logic [31:0] old, mrg;
        bit          inr;
        exp_t        e;
        inr = (int'(a) < dep(i));
        old = inr ? mdl[i][a] : 32'h0;
        mrg = old;
        for (int k = 0; k < 4; k++) if (b[k]) mrg[8*k +: 8] = d[8*k +: 8];
        e.cyc = cyc + lat(i);
        if (w) begin
            if (inr) mdl[i][a] = mrg;
            if (wm(i) == 2) return;
            e.data = (wm(i) == 1) ? (inr ? mrg : 32'h0) : old;
        end else begin
            e.data = old;
        end
        sb_push(i, e);
    endtask

    task automatic drive(input logic e, input logic w, input logic [3:0] b,
                         input logic [7:0] a, input logic [31:0] d, input bit track);
        @(posedge clk);
        #1;
        en = e; wen = w; be = b; addr = a; datai = d;
        if (e && track) begin
            for (int i = 0; i < 3; i++) model_acc(i, w, b, a, d);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    endtask

    task automatic model_zero();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 256; a++) mdl[i][a] = 32'h0;
        end
    endtask

    task automatic mon(input int i, input logic rv, input logic [31:0] d);
        exp_t e;
        bit   have;
        have = (sb_size(i) > 0);
        if (have) e = sb_front(i);
        if (rv) begin
            if (!have) begin
                check($sformatf("u%0d unexpected rvalid", i), {31'h0, rv}, 32'h0);
            end else begin
                sb_pop(i);
                check($sformatf("u%0d datao", i), d, e.data);
                check($sformatf("u%0d latency cycle", i), 32'(cyc), 32'(e.cyc));
                last_out[i] = e.data;
            end
        end else if (have && e.cyc <= cyc) begin
            sb_pop(i);
            check($sformatf("u%0d missing rvalid", i), {31'h0, rv}, 32'h1);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, rv_a, do_a);
            mon(1, rv_b, do_b);
            mon(2, rv_c, do_c);
        end
        if (bz_a) bcnt[0]++;
        if (bz_b) bcnt[1]++;
        if (bz_c) bcnt[2]++;
    end

    task automatic check_clear_done();
        check("u0 busy cycles", 32'(bcnt[0]), 32'(dep(0)));
        check("u1 busy cycles", 32'(bcnt[1]), 32'(dep(1)));
        check("u2 busy cycles", 32'(bcnt[2]), 32'(dep(2)));
        check("u0 busy low", {31'h0, bz_a}, 32'h0);
        check("u1 busy low", {31'h0, bz_b}, 32'h0);
        check("u2 busy low", {31'h0, bz_c}, 32'h0);
    endtask

    task automatic check_reset_state();
        check("u0 rst datao", do_a, 32'h0);
        check("u1 rst datao", do_b, 32'h0);
        check("u2 rst datao", do_c, 32'h0);
        check("u0 rst rvalid", {31'h0, rv_a}, 32'h0);
        check("u1 rst rvalid", {31'h0, rv_b}, 32'h0);
        check("u2 rst rvalid", {31'h0, rv_c}, 32'h0);
        check("u0 rst busy", {31'h0, bz_a}, 32'h0);
        check("u1 rst busy", {31'h0, bz_b}, 32'h0);
        check("u2 rst busy", {31'h0, bz_c}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            bcnt[i]     = 0;
            last_out[i] = 32'h0;
        end
        model_zero();

        // Reset state, then automatic clear after release; a read while busy is dropped.
        #22;
        check_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(10);
        drive(1'b1, 1'b0, 4'h0, 8'h7F, 32'h0, 1'b0);
        idle(290);
        check_clear_done();
        drive(1'b1, 1'b0, 4'h0, 8'h7F, 32'h0, 1'b1);
        idle(3);

        // Byte-enable merge.
        drive(1'b1, 1'b1, 4'b1111, 8'd5, 32'hDEADBEEF, 1'b1);
        drive(1'b1, 1'b1, 4'b0101, 8'd5, 32'h11223344, 1'b1);
        drive(1'b1, 1'b0, 4'h0,    8'd5, 32'h0,        1'b1);
        idle(3);

        // Same-address collision; NO_CHANGE instance must hold its last word.
        drive(1'b1, 1'b1, 4'b1111, 8'd9, 32'hAAAAAAAA, 1'b1);
        drive(1'b1, 1'b1, 4'b1111, 8'd9, 32'h55555555, 1'b1);
        idle(3);
        check("u2 datao hold", do_c, last_out[2]);

        // be=0 write changes nothing but still follows the write-mode read rule.
        drive(1'b1, 1'b1, 4'b0000, 8'd9, 32'h12345678, 1'b1);
        drive(1'b1, 1'b0, 4'h0,    8'd9, 32'h0,        1'b1);
        idle(3);

        // Back-to-back pipelined reads.
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 4'hF, 8'(k), 32'(10 + k), 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 4'h0, 8'(k), 32'h0, 1'b1);
        idle(4);
        check("u1 datao hold", do_b, last_out[1]);

        // Out-of-range write/read on the 200-word instance.
        drive(1'b1, 1'b1, 4'hF, 8'd199, 32'hCAFEF00D, 1'b1);
        drive(1'b1, 1'b1, 4'hF, 8'd250, 32'h000000FF, 1'b1);
        drive(1'b1, 1'b0, 4'h0, 8'd250, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 4'h0, 8'd199, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 4'h0, 8'd0,   32'h0, 1'b1);
        drive(1'b1, 1'b1, 4'hF, 8'd255, 32'h0BADBEEF, 1'b1);
        idle(4);

        // Requested clear aborted by reset at count 100, then full clear after release.
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        idle(100);
        check("u0 busy mid-clear", {31'h0, bz_a}, 32'h1);
        check("u1 busy mid-clear", {31'h0, bz_b}, 32'h1);
        check("u2 busy mid-clear", {31'h0, bz_c}, 32'h1);
        rst = 1'b0;
        #1;
        check_reset_state();
        for (int i = 0; i < 3; i++) begin
            bcnt[i]     = 0;
            last_out[i] = 32'h0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_zero();
        idle(300);
        check_clear_done();
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 4'h0, rd_list[k], 32'h0, 1'b1);
        idle(4);

        check("u0 scoreboard drained", 32'(sb_size(0)), 32'h0);
        check("u1 scoreboard drained", 32'(sb_size(1)), 32'h0);
        check("u2 scoreboard drained", 32'(sb_size(2)), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
